// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: parametrised N:1 data multiplexer with a single registered
// output stage and valid/ready flow control on every channel.
// Direct mode grants the channel addressed by sel. Round-robin mode searches
// the valid channels starting at a rotating pointer.
// Optional feature macro: MUX_RR_EN builds round-robin mode and its pointer.
// Without it, the mode port is ignored and only direct selection exists.
module mux_nto1_rr #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         mode,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_chan
);

    // Padded channel space so that any sel value indexes a defined bit;
    // indices at or beyond CHANNELS read as "not valid".
    localparam int                PAD_CH  = 1 << SEL_W;
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    out_data_r;
    logic                out_valid_r;
    logic [SEL_W-1:0]    out_chan_r;
    logic                load_en_s;
    logic                grant_any_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [PAD_CH-1:0]   valid_pad_s;
    logic [CHANNELS-1:0] in_ready_s;

    // Zero-extend the valid vector into the padded channel space
    always_comb begin
        valid_pad_s                 = '0;
        valid_pad_s[CHANNELS-1:0]   = in_valid;
    end

    // The output register may load when empty or when it is being popped
    assign load_en_s = !out_valid_r || out_ready;

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] rr_idx_s;
    logic             rr_any_s;

    // Find the first valid channel at or after ptr, wrapping around
    always_comb begin
        int               j;
        logic [SEL_W-1:0] cand;
        rr_idx_s = '0;
        rr_any_s = 1'b0;
        j        = 0;
        cand     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            j = int'(ptr_r) + k;
            if (j >= CHANNELS) begin
                j = j - CHANNELS;
            end else begin
                j = j;
            end
            cand = SEL_W'(j);
            if (!rr_any_s && valid_pad_s[cand]) begin
                rr_any_s = 1'b1;
                rr_idx_s = cand;
            end else begin
                rr_any_s = rr_any_s;
            end
        end
    end

    // Choose the grant source according to mode
    always_comb begin
        if (mode) begin
            grant_idx_s = rr_idx_s;
            grant_any_s = rr_any_s;
        end else begin
            grant_idx_s = sel;
            grant_any_s = valid_pad_s[sel];
        end
    end

    // Move the pointer just past every channel that transfers, in either mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (load_en_s && grant_any_s) begin
            ptr_r <= (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + SEL_W'(1'b1);
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;

    // Direct selection only: sel names the candidate channel
    always_comb begin
        grant_idx_s = sel;
        grant_any_s = valid_pad_s[sel];
    end
`endif

    // Accept exactly the granted channel, and only when the output can load
    always_comb begin
        in_ready_s = '0;
        if (rst_n && load_en_s && grant_any_s) begin
            in_ready_s = CHANNELS'(1'b1) << grant_idx_s;
        end else begin
            in_ready_s = '0;
        end
    end

    assign in_ready = in_ready_s;

    // Output stage: load on transfer, empty on an idle load slot, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_chan_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (load_en_s) begin
            if (grant_any_s) begin
                out_data_r  <= in_data[grant_idx_s*WIDTH +: WIDTH];
                out_chan_r  <= grant_idx_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed scenarios plus randomized traffic for mux_nto1_rr,
// compared cycle by cycle against a transaction-level reference model.
// Honours MUX_RR_EN the same way the design does.
module tb_mux_nto1_rr;

    localparam int WIDTH = 8;
    localparam int CH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_known = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;

    mux_nto1_rr #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which channel the rules grant for these inputs (-1 = none)
    function automatic int ref_grant(input logic [3:0] v, input logic [1:0] s,
                                     input logic md, input int p);
`ifdef MUX_RR_EN
        if (md) begin
            for (int k = 0; k < CH; k++) begin
                if (v[(p + k) % CH]) return (p + k) % CH;
            end
            return -1;
        end
`endif
        if (int'(s) < CH && v[s]) return int'(s);
        return -1;
    endfunction

    // Drive one cycle, check outputs against the model, then advance the model
    task automatic run_cycle(input logic r, input logic [3:0] v, input logic [31:0] d,
                             input logic [1:0] s, input logic md, input logic ordy);
        int         g;
        logic       load;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; sel = s; mode = md; out_ready = ordy;
        #1;
        if (m_known) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_chan", 32'(out_chan), 32'(m_chan));
        end
        if (!r) begin
            check("in_ready_rst", 32'(in_ready), 32'h0);
            m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 0; m_known = 1'b1;
        end else begin
            load    = !m_valid || ordy;
            g       = load ? ref_grant(v, s, md, m_ptr) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (load) begin
                if (g >= 0) begin
                    m_data  = d[g*WIDTH +: WIDTH];
                    m_chan  = g;
                    m_valid = 1'b1;
                    m_ptr   = (g + 1) % CH;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq[6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0; in_valid = 4'h0; in_data = 32'h0; sel = 2'd0; mode = 1'b0; out_ready = 1'b0;

        // Reset with every channel requesting
        run_cycle(1'b0, 4'b1111, 32'hDEADBEEF, 2'd0, 1'b1, 1'b1);
        run_cycle(1'b0, 4'b1111, 32'hCAFEF00D, 2'd1, 1'b0, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);

        // Direct mode, channel 2 carries 8'hA5
        run_cycle(1'b1, 4'b0100, 32'h00A5_0000, 2'd2, 1'b0, 1'b1);
        check("a5_out_data", 32'(out_data), 32'hA5);
        check("a5_out_chan", 32'(out_chan), 32'h2);
        check("a5_out_valid", 32'(out_valid), 32'h1);

        // Direct mode, selected channel idle: nothing granted, output drains
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b1101, 32'h1122_3344, 2'd1, 1'b0, 1'b1);
        check("idle_out_valid", 32'(out_valid), 32'h0);

`ifdef MUX_RR_EN
        // Round-robin rotation from a fresh reset
        run_cycle(1'b0, 4'b0000, 32'h0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 4'b1111, $urandom, 2'd0, 1'b1, 1'b1);
            check("rr_rotate_chan", 32'(out_chan), 32'(exp_seq[i]));
        end
`endif

        // Backpressure: hold 8'h3C while the consumer stalls
        run_cycle(1'b1, 4'b0001, 32'h0000_003C, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 4'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'b0);
            check("stall_out_data", 32'(out_data), 32'h3C);
            check("stall_out_valid", 32'(out_valid), 32'h1);
        end
        run_cycle(1'b1, 4'b0100, 32'h0077_0000, 2'd2, 1'b0, 1'b1);
        check("unstall_out_data", 32'(out_data), 32'h77);
        check("unstall_out_chan", 32'(out_chan), 32'h2);

`ifdef MUX_RR_EN
        // Round-robin skips idle channels: 1 then 3 then 1
        run_cycle(1'b1, 4'b0010, 32'h0000_5500, 2'd0, 1'b1, 1'b1);
        check("rr_skip_first", 32'(out_chan), 32'h1);
        run_cycle(1'b1, 4'b1010, 32'h6600_7700, 2'd0, 1'b1, 1'b1);
        check("rr_skip_to3", 32'(out_chan), 32'h3);
        run_cycle(1'b1, 4'b1010, 32'h8800_9900, 2'd0, 1'b1, 1'b1);
        check("rr_skip_to1", 32'(out_chan), 32'h1);
`else
        // Without round-robin, mode=1 still selects directly
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 4'b1010, $urandom, 2'd3, 1'b1, 1'b1);
            check("direct_mode1_chan", 32'(out_chan), 32'h3);
            check("direct_mode1_ready", 32'(in_ready), 32'h8);
        end
`endif

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 29) != 0), 4'($urandom), $urandom,
                      2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
